// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
//   Sequential reverse-double-dabble converter. It turns a 4-digit packed BCD
//   value (0000-9999) into a 16-bit unsigned binary value.
//   It uses a one-strobe-in / one-pulse-out handshake.
//
//   Optional feature macro: BCD2BIN_DIGIT_CHECK_EN
//     When it is defined, LOAD rejects any nibble greater than 9. The FSM then
//     skips straight to DONE, which reports bin_out = 0 and dec_err = 1.
//     When it is undefined, no check is made and dec_err is tied to 0.
//
// Ports
//   clk                 in   1   system clock, rising edge
//   rst                 in   1   synchronous, active-high reset
//   dec_in              in  16   packed BCD {thousands, hundreds, tens, units}
//   data_from_dec_rcvd  in   1   start strobe, sampled in IDLE only
//   bin_out             out 16   conversion result, held until the next DONE
//   data_from_bin_trcvd out  1   one-clock done pulse
//   busy                out  1   high in every state other than IDLE
//   dec_err             out  1   invalid-digit flag (check feature only)
// ---------------------------------------------------------------------------
module bcd_to_bin (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dec_in,
  input  logic        data_from_dec_rcvd,
  output logic [15:0] bin_out,
  output logic        data_from_bin_trcvd,
  output logic        busy,
  output logic        dec_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [15:0] bcd;
  logic [15:0] bin;
  logic [4:0]  i;
  logic        load_bad;

  // Per-nibble correction that undoes the doubling: any nibble >= 8 loses 3.
  // Each nibble wraps on its own; no borrow crosses nibble boundaries.
  function automatic logic [15:0] sub3(input logic [15:0] v);
    logic [15:0] r;
    logic [3:0]  n;
    r = v;
    for (int k = 0; k < 4; k++) begin
      n = v[4*k +: 4];
      r[4*k +: 4] = (n >= 4'd8) ? n - 4'd3 : n;
    end
    return r;
  endfunction

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_q;

  function automatic logic has_bad_digit(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < 4; k++)
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  assign load_bad = has_bad_digit(dec_in);
`else
  assign load_bad = 1'b0;
  assign dec_err  = 1'b0;
`endif

  // Next-state logic.
  // NOTE: assigning the default first keeps every path covered, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (data_from_dec_rcvd) state_nx = LOAD;
      LOAD:    state_nx = load_bad ? DONE : SHIFT;
      SHIFT:   state_nx = SUB;
      SUB:     state_nx = (i == 5'd16) ? DONE : SHIFT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  // NOTE: non-blocking assignments let every register see the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      bcd                 <= '0;
      bin                 <= '0;
      i                   <= '0;
      bin_out             <= '0;
      data_from_bin_trcvd <= 1'b0;
      busy                <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q               <= 1'b0;
      dec_err             <= 1'b0;
`endif
    end else begin
      state               <= state_nx;
      // busy is registered from the next state, so it tracks state != IDLE.
      busy                <= (state_nx != IDLE);
      data_from_bin_trcvd <= (state == DONE);

      case (state)
        LOAD: begin
          bcd <= dec_in;
          bin <= '0;
          i   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_q <= load_bad;
`endif
        end
        SHIFT: begin
          // 32-bit right shift of {bcd, bin}: bcd[0] moves into bin[15].
          {bcd, bin} <= {1'b0, bcd, bin[15:1]};
          i          <= i + 5'd1;
        end
        SUB: begin
          bcd <= sub3(bcd);
        end
        DONE: begin
          i <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          bin_out <= err_q ? 16'h0000 : bin;
          dec_err <= err_q;
`else
          bin_out <= bin;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin
//   Directed-vector self-checking bench for bcd_to_bin. The expected values
//   are hand-computed decimal-to-hex constants.
//   It covers these cases:
//     - reset values
//     - latency and result for several inputs
//     - a strobe during a conversion, which must be ignored
//     - a reset in mid-conversion
//     - back-to-back conversions with the strobe held high
//     - the invalid-digit path, when BCD2BIN_DIGIT_CHECK_EN is defined
// ---------------------------------------------------------------------------
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dec_in = '0;
  logic        data_from_dec_rcvd = 1'b0;
  logic [15:0] bin_out;
  logic        data_from_bin_trcvd;
  logic        busy;
  logic        dec_err;

  int n_tests  = 0;
  int n_failed = 0;

  bcd_to_bin dut (
    .clk                 (clk),
    .rst                 (rst),
    .dec_in              (dec_in),
    .data_from_dec_rcvd  (data_from_dec_rcvd),
    .bin_out             (bin_out),
    .data_from_bin_trcvd (data_from_bin_trcvd),
    .busy                (busy),
    .dec_err             (dec_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one conversion whose strobe is sampled at edge E0, then observes
  // edges E1..E40, sampling each one 1 ns after the edge.
  //   restrobe_at: edge at which the strobe is pulsed again (0 = never)
  //   rst_at:      edge at which reset is pulsed (0 = never)
  // Outputs:
  //   lat:      first edge that showed done high (0 = none)
  //   pulses:   number of sampled edges with done high
  //   busy_bad: count of edges E1..E34 where busy != (edge < E34)
  task automatic run(input logic [15:0] d, input int restrobe_at, input int rst_at,
                     output int lat, output int pulses, output int busy_bad);
    lat = 0; pulses = 0; busy_bad = 0;
    @(negedge clk);
    dec_in = d;
    data_from_dec_rcvd = 1'b1;
    @(posedge clk);
    #1;
    data_from_dec_rcvd = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      data_from_dec_rcvd = (n == restrobe_at);
      rst = (n == rst_at);
      @(posedge clk);
      #1;
      if (data_from_bin_trcvd) begin
        pulses++;
        if (lat == 0) lat = n;
      end
      if (n <= 34 && busy !== (n < 34)) busy_bad++;
      if (n == rst_at) begin
        check("rst_mid bin_out", bin_out, 16'h0000);
        check("rst_mid done", data_from_bin_trcvd, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid dec_err", dec_err, 0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    data_from_dec_rcvd = 1'b0;
  endtask

  initial begin
    int lat, pulses, busy_bad;
    int hits[$];

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset bin_out", bin_out, 16'h0000);
    check("reset done", data_from_bin_trcvd, 0);
    check("reset busy", busy, 0);
    check("reset dec_err", dec_err, 0);

    // 9999 -> 0x270F, maximum value
    run(16'h9999, 0, 0, lat, pulses, busy_bad);
    check("9999 latency", lat, 34);
    check("9999 pulses", pulses, 1);
    check("9999 bin_out", bin_out, 16'h270F);
    check("9999 dec_err", dec_err, 0);
    check("9999 busy", busy_bad, 0);

    // 1234 -> 0x04D2
    run(16'h1234, 0, 0, lat, pulses, busy_bad);
    check("1234 latency", lat, 34);
    check("1234 bin_out", bin_out, 16'h04D2);

    // 0000 -> 0x0000
    run(16'h0000, 0, 0, lat, pulses, busy_bad);
    check("0000 latency", lat, 34);
    check("0000 pulses", pulses, 1);
    check("0000 bin_out", bin_out, 16'h0000);

    // 0500 -> 0x01F4; a strobe at E10 must be ignored
    run(16'h0500, 10, 0, lat, pulses, busy_bad);
    check("0500 latency", lat, 34);
    check("0500 pulses", pulses, 1);
    check("0500 bin_out", bin_out, 16'h01F4);
    check("0500 busy", busy_bad, 0);

`ifdef BCD2BIN_DIGIT_CHECK_EN
    // invalid digit: done at E2 with a zero result and the error flag set
    run(16'h12A4, 0, 0, lat, pulses, busy_bad);
    check("12A4 latency", lat, 2);
    check("12A4 pulses", pulses, 1);
    check("12A4 bin_out", bin_out, 16'h0000);
    check("12A4 dec_err", dec_err, 1);
    run(16'h0042, 0, 0, lat, pulses, busy_bad);
    check("0042 latency", lat, 34);
    check("0042 bin_out", bin_out, 16'h002A);
    check("0042 dec_err", dec_err, 0);
`endif

    // a reset at E20 aborts the conversion: no done pulse, all outputs cleared
    run(16'h0777, 0, 20, lat, pulses, busy_bad);
    check("rst_abort pulses", pulses, 0);
    run(16'h0777, 0, 0, lat, pulses, busy_bad);
    check("0777 latency", lat, 34);
    check("0777 bin_out", bin_out, 16'h0309);

    // strobe held high: done at E34, then every 35 cycles
    @(negedge clk);
    dec_in = 16'h0001;
    data_from_dec_rcvd = 1'b1;
    for (int c = 0; c <= 150; c++) begin
      @(posedge clk);
      #1;
      if (data_from_bin_trcvd) begin
        hits.push_back(c);
        check("hold bin_out", bin_out, 16'h0001);
      end
    end
    @(negedge clk);
    data_from_dec_rcvd = 1'b0;
    check("hold pulse count", hits.size(), 4);
    if (hits.size() > 0) check("hold first latency", hits[0], 34);
    for (int k = 1; k < hits.size(); k++)
      check("hold period", hits[k] - hits[k-1], 35);
    repeat (40) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
